// File: rtl/triangle_scanner.sv
// Bounding-box scanner: walks every pixel of a triangle's clamped bounding box and issues framebuffer writes.
// Optional build macro TRIANGLE_SCANNER_CULL_BLACK_EN skips pixels whose rasterizer colour is black.
`ifndef FIXEDPOINT_WIDTH
`define FIXEDPOINT_WIDTH 32
`endif

module triangle_scanner #(
   parameter int SCREEN_WIDTH  = 64,
   parameter int SCREEN_HEIGHT = 64,
   parameter int FRAC_BITS     = 16,
   localparam int ADDR_W       = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT)
) (
   input  logic                                i_clk,
   input  logic                                i_reset,
   input  logic                                i_start,
   input  logic signed [`FIXEDPOINT_WIDTH-1:0] i_v1x,
   input  logic signed [`FIXEDPOINT_WIDTH-1:0] i_v1y,
   input  logic signed [`FIXEDPOINT_WIDTH-1:0] i_v2x,
   input  logic signed [`FIXEDPOINT_WIDTH-1:0] i_v2y,
   input  logic signed [`FIXEDPOINT_WIDTH-1:0] i_v3x,
   input  logic signed [`FIXEDPOINT_WIDTH-1:0] i_v3y,
   output logic signed [`FIXEDPOINT_WIDTH-1:0] o_x,
   output logic signed [`FIXEDPOINT_WIDTH-1:0] o_y,
   input  logic [7:0]                          i_r,
   input  logic [7:0]                          i_g,
   input  logic [7:0]                          i_b,
   output logic                                o_fb_valid,
   input  logic                                i_fb_ready,
   output logic [ADDR_W-1:0]                   o_fb_addr,
   output logic [23:0]                         o_fb_data,
   output logic                                o_busy,
   output logic                                o_done
);

   localparam int FW = `FIXEDPOINT_WIDTH;
   localparam int XW = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
   localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
   localparam logic signed [FW-1:0] XHI = FW'(SCREEN_WIDTH - 1);
   localparam logic signed [FW-1:0] YHI = FW'(SCREEN_HEIGHT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_SCAN  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state_r, state_nxt_s;

   logic signed [FW-1:0] v1x_r, v1y_r, v2x_r, v2y_r, v3x_r, v3y_r;
   logic signed [FW-1:0] ix1_s, iy1_s, ix2_s, iy2_s, ix3_s, iy3_s;
   logic signed [FW-1:0] bx_min_s, bx_max_s, by_min_s, by_max_s;
   logic [XW-1:0]        cxmin_s, cxmax_s;
   logic [YW-1:0]        cymin_s, cymax_s;
   logic                 reject_s;

   logic [XW-1:0]     xmin_r, xmax_r, x_r, x_nxt_s, x_fin_s;
   logic [YW-1:0]     ymax_r, y_r, y_nxt_s, y_fin_s;
   logic [ADDR_W-1:0] addr_r, addr_nxt_s;

   logic        scan_s, valid_s, skip_s, adv_s;
   logic [23:0] pix_s;

   function automatic logic signed [FW-1:0] min3(input logic signed [FW-1:0] a,
                                                 input logic signed [FW-1:0] b,
                                                 input logic signed [FW-1:0] c);
      logic signed [FW-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic signed [FW-1:0] max3(input logic signed [FW-1:0] a,
                                                 input logic signed [FW-1:0] b,
                                                 input logic signed [FW-1:0] c);
      logic signed [FW-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   function automatic logic [XW-1:0] clamp_x(input logic signed [FW-1:0] v);
      logic [XW-1:0] r;
      if (v[FW-1])       r = {XW{1'b0}};
      else if (v > XHI)  r = XHI[XW-1:0];
      else               r = v[XW-1:0];
      return r;
   endfunction

   function automatic logic [YW-1:0] clamp_y(input logic signed [FW-1:0] v);
      logic [YW-1:0] r;
      if (v[FW-1])       r = {YW{1'b0}};
      else if (v > YHI)  r = YHI[YW-1:0];
      else               r = v[YW-1:0];
      return r;
   endfunction

   // Arithmetic shift floors toward minus infinity, matching pixel ownership of negative coordinates.
   assign ix1_s = v1x_r >>> FRAC_BITS;
   assign iy1_s = v1y_r >>> FRAC_BITS;
   assign ix2_s = v2x_r >>> FRAC_BITS;
   assign iy2_s = v2y_r >>> FRAC_BITS;
   assign ix3_s = v3x_r >>> FRAC_BITS;
   assign iy3_s = v3y_r >>> FRAC_BITS;

   assign bx_min_s = min3(ix1_s, ix2_s, ix3_s);
   assign bx_max_s = max3(ix1_s, ix2_s, ix3_s);
   assign by_min_s = min3(iy1_s, iy2_s, iy3_s);
   assign by_max_s = max3(iy1_s, iy2_s, iy3_s);

   assign cxmin_s = clamp_x(bx_min_s);
   assign cxmax_s = clamp_x(bx_max_s);
   assign cymin_s = clamp_y(by_min_s);
   assign cymax_s = clamp_y(by_max_s);

   assign reject_s = bx_max_s[FW-1] | by_max_s[FW-1] | (bx_min_s > XHI) | (by_min_s > YHI);

   assign scan_s = (state_r == S_SCAN);
   assign pix_s  = {i_r, i_g, i_b};

`ifdef TRIANGLE_SCANNER_CULL_BLACK_EN
   assign valid_s = scan_s & (pix_s != 24'd0);
   assign skip_s  = scan_s & (pix_s == 24'd0);
`else
   assign valid_s = scan_s;
   assign skip_s  = 1'b0;
`endif

   assign adv_s = (valid_s & i_fb_ready) | skip_s;

   // Next-state and row-major pixel stepping
   always_comb begin
      state_nxt_s = state_r;
      x_nxt_s     = x_r;
      y_nxt_s     = y_r;
      case (state_r)
         S_IDLE: begin
            if (i_start) state_nxt_s = S_SETUP;
            else         state_nxt_s = S_IDLE;
         end
         S_SETUP: begin
            if (reject_s) begin
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_SCAN;
               x_nxt_s     = cxmin_s;
               y_nxt_s     = cymin_s;
            end
         end
         S_SCAN: begin
            if (adv_s) begin
               if (x_r == xmax_r) begin
                  if (y_r == ymax_r) begin
                     state_nxt_s = S_DONE;
                  end else begin
                     x_nxt_s = xmin_r;
                     y_nxt_s = y_r + 1'b1;
                  end
               end else begin
                  x_nxt_s = x_r + 1'b1;
               end
            end else begin
               state_nxt_s = S_SCAN;
            end
         end
         S_DONE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Counters read as zero whenever no scan is in progress, so o_x/o_y/o_fb_addr idle at 0.
   assign x_fin_s    = (state_nxt_s == S_SCAN) ? x_nxt_s : {XW{1'b0}};
   assign y_fin_s    = (state_nxt_s == S_SCAN) ? y_nxt_s : {YW{1'b0}};
   assign addr_nxt_s = ADDR_W'(y_fin_s) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(x_fin_s);

   // State, pixel counters, address and vertex/bounding-box capture
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r <= S_IDLE;
         x_r     <= {XW{1'b0}};
         y_r     <= {YW{1'b0}};
         addr_r  <= {ADDR_W{1'b0}};
         xmin_r  <= {XW{1'b0}};
         xmax_r  <= {XW{1'b0}};
         ymax_r  <= {YW{1'b0}};
         v1x_r   <= {FW{1'b0}};
         v1y_r   <= {FW{1'b0}};
         v2x_r   <= {FW{1'b0}};
         v2y_r   <= {FW{1'b0}};
         v3x_r   <= {FW{1'b0}};
         v3y_r   <= {FW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         x_r     <= x_fin_s;
         y_r     <= y_fin_s;
         addr_r  <= addr_nxt_s;
         if ((state_r == S_IDLE) && i_start) begin
            v1x_r <= i_v1x;
            v1y_r <= i_v1y;
            v2x_r <= i_v2x;
            v2y_r <= i_v2y;
            v3x_r <= i_v3x;
            v3y_r <= i_v3y;
         end
         if (state_r == S_SETUP) begin
            xmin_r <= cxmin_s;
            xmax_r <= cxmax_s;
            ymax_r <= cymax_s;
         end
      end
   end

   assign o_x        = signed'(FW'(x_r) << FRAC_BITS);
   assign o_y        = signed'(FW'(y_r) << FRAC_BITS);
   assign o_fb_valid = valid_s;
   assign o_fb_addr  = addr_r;
   assign o_fb_data  = scan_s ? pix_s : 24'd0;
   assign o_busy     = (state_r != S_IDLE);
   assign o_done     = (state_r == S_DONE);

endmodule

// File: tb/tb_triangle_scanner.sv
// Self-checking bench for triangle_scanner on an 8x8 screen: directed cases plus random triangles
// compared against a bounding-box reference model built with real-valued floor and plain loops.
`ifndef FIXEDPOINT_WIDTH
`define FIXEDPOINT_WIDTH 32
`endif

module tb_triangle_scanner;
   localparam int W     = 8;
   localparam int H     = 8;
   localparam int FB    = 16;
   localparam int FW    = `FIXEDPOINT_WIDTH;
   localparam int AW    = $clog2(W*H);
   localparam int BOUND = 400;
   localparam int ONE   = 65536;
`ifdef TRIANGLE_SCANNER_CULL_BLACK_EN
   localparam bit CULL = 1'b1;
`else
   localparam bit CULL = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 i_reset, i_start, i_fb_ready;
   logic signed [FW-1:0] v1x, v1y, v2x, v2y, v3x, v3y;
   logic signed [FW-1:0] o_x, o_y;
   logic [7:0]           i_r, i_g, i_b;
   logic                 o_fb_valid, o_busy, o_done;
   logic [AW-1:0]        o_fb_addr;
   logic [23:0]          o_fb_data;

   int checks = 0;
   int errors = 0;
   int black_addr = -1;
   int exp_a[$];
   int exp_x[$];
   int exp_y[$];

   triangle_scanner #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .FRAC_BITS(FB)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
      .i_v1x(v1x), .i_v1y(v1y), .i_v2x(v2x), .i_v2y(v2y), .i_v3x(v3x), .i_v3y(v3y),
      .o_x(o_x), .o_y(o_y), .i_r(i_r), .i_g(i_g), .i_b(i_b),
      .o_fb_valid(o_fb_valid), .i_fb_ready(i_fb_ready),
      .o_fb_addr(o_fb_addr), .o_fb_data(o_fb_data),
      .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   // Rasterizer stand-in: a colour that depends on the pixel, black only at black_addr.
   function automatic logic [23:0] color(input int x, input int y, input int blk);
      if (y*W + x == blk) return 24'h000000;
      return {8'(x*16 + y + 1), 8'(x ^ y), 8'hA5};
   endfunction

   always_comb {i_r, i_g, i_b} = color(int'(o_x >>> FB), int'(o_y >>> FB), black_addr);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: every pixel of the screen-clipped bounding box, row-major.
   task automatic build(input int x1, input int y1, input int x2, input int y2, input int x3, input int y3);
      int vx[3];
      int vy[3];
      int ix[3];
      int iy[3];
      int xmn, xmx, ymn, ymx;
      vx = '{x1, x2, x3};
      vy = '{y1, y2, y3};
      exp_a.delete(); exp_x.delete(); exp_y.delete();
      for (int i = 0; i < 3; i++) begin
         ix[i] = int'($floor(real'(vx[i]) / 65536.0));
         iy[i] = int'($floor(real'(vy[i]) / 65536.0));
      end
      xmn = ix[0]; xmx = ix[0]; ymn = iy[0]; ymx = iy[0];
      for (int i = 1; i < 3; i++) begin
         if (ix[i] < xmn) xmn = ix[i];
         if (ix[i] > xmx) xmx = ix[i];
         if (iy[i] < ymn) ymn = iy[i];
         if (iy[i] > ymx) ymx = iy[i];
      end
      if (xmx < 0 || ymx < 0 || xmn > W-1 || ymn > H-1) return;
      if (xmn < 0) xmn = 0;
      if (ymn < 0) ymn = 0;
      if (xmx > W-1) xmx = W-1;
      if (ymx > H-1) ymx = H-1;
      for (int y = ymn; y <= ymx; y++)
         for (int x = xmn; x <= xmx; x++)
            if (!(CULL && color(x, y, black_addr) == 24'h0)) begin
               exp_a.push_back(y*W + x);
               exp_x.push_back(x);
               exp_y.push_back(y);
            end
   endtask

   // mode 0: always ready, 1: random ready plus stray i_start, 2: stall 3 cycles at addr 10.
   task automatic scan(input int x1, input int y1, input int x2, input int y2, input int x3, input int y3,
                       input int mode, input int rst_after, input string tag);
      int last, acc, total, stall, cnt10;
      bit done_seen, rst_pend;
      last = 1; acc = 0; stall = 0; cnt10 = 0; done_seen = 1'b0; rst_pend = 1'b0;
      build(x1, y1, x2, y2, x3, y3);
      total = exp_a.size();
      @(negedge clk);
      v1x = x1; v1y = y1; v2x = x2; v2y = y2; v3x = x3; v3y = y3;
      i_start = 1'b1; i_fb_ready = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      for (int k = 1; k <= BOUND; k++) begin
         if (rst_pend) begin
            i_reset = 1'b1; i_fb_ready = 1'b0;
            @(negedge clk);
            chk({tag, "/rst_busy"}, o_busy, 1'b0);
            chk({tag, "/rst_done"}, o_done, 1'b0);
            chk({tag, "/rst_valid"}, o_fb_valid, 1'b0);
            chk({tag, "/rst_addr"}, o_fb_addr, 0);
            chk({tag, "/rst_data"}, o_fb_data, 0);
            chk({tag, "/rst_x"}, o_x, 0);
            chk({tag, "/rst_y"}, o_y, 0);
            i_reset = 1'b0; i_fb_ready = 1'b1;
            repeat (6) begin
               @(negedge clk);
               chk({tag, "/no_done_after_rst"}, o_done, 1'b0);
               chk({tag, "/no_write_after_rst"}, o_fb_valid, 1'b0);
            end
            return;
         end
         if (k == 1) begin
            chk({tag, "/setup_busy"}, o_busy, 1'b1);
            chk({tag, "/setup_valid"}, o_fb_valid, 1'b0);
         end
         if (k == 2 && total > 0 && !CULL) chk({tag, "/first_write_at_2"}, o_fb_valid, 1'b1);
         if (o_done) begin
            chk({tag, "/done_timing"}, k, last + 1);
            chk({tag, "/done_valid"}, o_fb_valid, 1'b0);
            done_seen = 1'b1;
            break;
         end
         if (o_fb_valid) begin
            if (exp_a.size() == 0) begin
               chk({tag, "/write_count"}, acc + 1, total);
            end else begin
               chk({tag, "/addr"}, o_fb_addr, exp_a[0]);
               chk({tag, "/data"}, o_fb_data, color(exp_x[0], exp_y[0], black_addr));
               chk({tag, "/o_x"}, o_x, exp_x[0] * ONE);
               chk({tag, "/o_y"}, o_y, exp_y[0] * ONE);
            end
            if (o_fb_addr == 10) cnt10++;
            case (mode)
               1: i_fb_ready = 1'($urandom_range(0, 1));
               2: begin
                  if (o_fb_addr == 10 && stall < 3) begin
                     stall++;
                     i_fb_ready = 1'b0;
                  end else begin
                     i_fb_ready = 1'b1;
                  end
               end
               default: i_fb_ready = 1'b1;
            endcase
            if (i_fb_ready) begin
               if (exp_a.size() > 0) begin
                  void'(exp_a.pop_front()); void'(exp_x.pop_front()); void'(exp_y.pop_front());
               end
               acc++;
               last = k;
               if (rst_after > 0 && acc == rst_after) rst_pend = 1'b1;
            end
         end
         if (mode == 1 && $urandom_range(0, 4) == 0) begin
            i_start = 1'b1;
            v1x = $urandom; v2y = $urandom;
         end else begin
            i_start = 1'b0;
         end
         @(negedge clk);
      end
      i_start = 1'b0;
      chk({tag, "/done_seen"}, done_seen, 1'b1);
      chk({tag, "/total_writes"}, acc, total);
      if (mode == 2) chk({tag, "/addr10_held_cycles"}, cnt10, 4);
      @(negedge clk);
      chk({tag, "/idle_busy"}, o_busy, 1'b0);
      chk({tag, "/idle_done"}, o_done, 1'b0);
   endtask

   initial begin
      int rx[6];
      i_reset = 1'b1; i_start = 1'b0; i_fb_ready = 1'b0;
      v1x = 0; v1y = 0; v2x = 0; v2y = 0; v3x = 0; v3y = 0;
      repeat (2) @(negedge clk);
      chk("reset/busy", o_busy, 1'b0);
      chk("reset/done", o_done, 1'b0);
      chk("reset/valid", o_fb_valid, 1'b0);
      chk("reset/addr", o_fb_addr, 0);
      chk("reset/data", o_fb_data, 0);
      chk("reset/x", o_x, 0);
      chk("reset/y", o_y, 0);
      i_reset = 1'b0;

      scan(1*ONE, 1*ONE, 4*ONE, 1*ONE, 1*ONE, 4*ONE, 0, 0, "tri");
      scan(1*ONE, 1*ONE, 4*ONE, 1*ONE, 1*ONE, 4*ONE, 2, 0, "stall");
      scan(-3*ONE, -1*ONE, -1*ONE, -5*ONE, -2*ONE, -2*ONE, 0, 0, "offscreen");
      scan(5*ONE, 2*ONE, 10*ONE, 2*ONE, 5*ONE, 3*ONE, 0, 0, "clampx");
      scan(1*ONE, 1*ONE, 4*ONE, 1*ONE, 1*ONE, 4*ONE, 0, 5, "reset_mid");
      scan(1*ONE, 1*ONE, 4*ONE, 1*ONE, 1*ONE, 4*ONE, 0, 0, "rescan");
      scan(-5*ONE, -5*ONE, 20*ONE, -5*ONE, -5*ONE, 20*ONE, 0, 0, "fullscreen");
      scan(-ONE/2, 7*ONE + ONE/2, ONE/4, 6*ONE, 0, 9*ONE, 1, 0, "fraction_floor");

      // Reset wins over a simultaneous start.
      @(negedge clk);
      i_reset = 1'b1; i_start = 1'b1;
      @(negedge clk);
      i_reset = 1'b0; i_start = 1'b0;
      chk("rst_vs_start/busy", o_busy, 1'b0);
      @(negedge clk);
      chk("rst_vs_start/still_idle", o_busy, 1'b0);

`ifdef TRIANGLE_SCANNER_CULL_BLACK_EN
      black_addr = 12;
      scan(1*ONE, 1*ONE, 4*ONE, 1*ONE, 1*ONE, 4*ONE, 0, 0, "cull_black");
      chk("cull_black/expected_len", 15, 15 + exp_a.size());
      black_addr = -1;
`endif

      repeat (25) begin
         for (int i = 0; i < 6; i++)
            rx[i] = (int'($urandom_range(0, 15)) - 4) * ONE + int'($urandom_range(0, 65535));
         scan(rx[0], rx[1], rx[2], rx[3], rx[4], rx[5], 1, 0, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/triangle_scanner.md
TRIANGLE_SCANNER -- requirements
Module: triangle_scanner

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 64, the framebuffer width in pixels.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 64, the framebuffer height in pixels.
REQ-003 SHALL have parameter FRAC_BITS, default 16, the number of fraction bits in the `FIXEDPOINT_WIDTH-bit signed coordinate format.
REQ-004 SHALL define the derived width ADDR_W = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT).
REQ-005 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_start  input  1  one-cycle request to scan the current triangle.
REQ-008 i_v1x,i_v1y,i_v2x,i_v2y,i_v3x,i_v3y  input  `FIXEDPOINT_WIDTH each, signed  vertex screen positions; sampled on the i_start cycle only.
REQ-009 o_x,o_y  output  `FIXEDPOINT_WIDTH each, signed  current pixel position to the downstream rasterizer: integer pixel << FRAC_BITS, fraction zero.
REQ-010 i_r,i_g,i_b  input  8 each  rasterizer colour for (o_x,o_y), valid combinationally in the same cycle.
REQ-011 o_fb_valid  output  1  framebuffer write request.
REQ-012 i_fb_ready  input  1  framebuffer accepts the write when high together with o_fb_valid.
REQ-013 o_fb_addr  output  ADDR_W  write address = y*SCREEN_WIDTH + x.
REQ-014 o_fb_data  output  24  write data {r,g,b}.
REQ-015 o_busy  output  1  high in every state except IDLE.
REQ-016 o_done  output  1  one-cycle pulse when a scan completes.

Function
REQ-017 SHALL implement the states IDLE, SETUP, SCAN and DONE.
REQ-018 IDLE: when i_start=1, SHALL latch all six vertex coordinates and go to SETUP; otherwise it SHALL remain in IDLE.
REQ-019 i_start while o_busy=1 SHALL be ignored and SHALL NOT disturb the scan in progress.
REQ-020 SETUP (exactly 1 cycle) SHALL compute integer coordinates by arithmetic shift right by FRAC_BITS (floor).
REQ-021 SETUP SHALL compute xmin/xmax/ymin/ymax as the min/max of the three vertices.
REQ-022 SETUP SHALL clamp x to [0, SCREEN_WIDTH-1] and y to [0, SCREEN_HEIGHT-1].
REQ-023 SETUP SHALL go to DONE, with no writes, if unclamped xmax<0, ymax<0, xmin>SCREEN_WIDTH-1 or ymin>SCREEN_HEIGHT-1; otherwise it SHALL set x=xmin, y=ymin and go to SCAN.
REQ-024 SCAN SHALL drive o_fb_valid=1, with o_fb_addr and o_fb_data derived from the current x,y and i_r/i_g/i_b.
REQ-025 SCAN SHALL hold o_fb_valid, o_fb_addr and o_x/o_y stable until the cycle in which i_fb_ready=1.
REQ-026 On each accepted write (valid&&ready), SCAN SHALL advance in row-major order: x+1, or x=xmin and y+1 when x==xmax.
REQ-027 SHALL go to DONE on the write accepted at (xmax,ymax).
REQ-028 DONE SHALL assert o_done=1 for exactly one cycle, then return to IDLE.
REQ-029 SHALL accept at most one write per cycle; the first write SHALL be presented 2 cycles after i_start.
REQ-030 SHALL be able to scan an entire screen-sized box, with x and y counters wide enough for SCREEN_WIDTH-1 and SCREEN_HEIGHT-1.
REQ-031 Address arithmetic SHALL be unsigned and SHALL NOT overflow ADDR_W.
REQ-032 o_fb_valid SHALL be 0 in IDLE, SETUP and DONE.

Reset
REQ-033 While i_reset=1, SHALL enter IDLE with o_busy=0, o_done=0, o_fb_valid=0, o_fb_addr=0, o_fb_data=0, o_x=0 and o_y=0.
REQ-034 Reset during SETUP or SCAN SHALL abort the scan: no further writes and no o_done pulse.
REQ-035 Reset SHALL take priority over a simultaneous i_start.

Configuration
REQ-036 Macro TRIANGLE_SCANNER_CULL_BLACK_EN: when defined, a SCAN pixel with {i_r,i_g,i_b}==0 SHALL NOT be written; o_fb_valid=0 and the scan SHALL advance one pixel that cycle without waiting for i_fb_ready.
REQ-037 When TRIANGLE_SCANNER_CULL_BLACK_EN is undefined, every pixel in the bounding box SHALL be written, including black ones.

Verification (SCREEN 8x8, FRAC_BITS 16)
REQ-038 Vertices (1,1),(4,1),(1,4), i_fb_ready=1 -> 16 writes at addresses 9,10,11,12,17,...,36 in order; first write 2 cycles after i_start; o_done pulses 1 cycle after the write at addr 36.
REQ-039 Same triangle, i_fb_ready low for 3 cycles at the addr 10 write -> addr 10 and its data held for 4 cycles; total still 16 writes.
REQ-040 Vertices (-3,-1),(-1,-5),(-2,-2) -> zero writes; o_done 2 cycles after i_start; o_busy low again the next cycle.
REQ-041 Vertices (5,2),(10,2),(5,3) -> x clamped to 5..7; writes 21,22,23,29,30,31.
REQ-042 i_reset asserted after the 5th write of REQ-038 -> all outputs 0 the next cycle, no o_done; a new i_start then rescans from addr 9.
REQ-043 With TRIANGLE_SCANNER_CULL_BLACK_EN defined and the rasterizer returning black at the addr 12 pixel -> 15 writes, none to addr 12.
